// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } ind_phase_t;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones and clears only on reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// LC-3 pipeline stall/flush controller: memory handshakes, load-use bubbles,
// branch flushes and LDI/STI two-access sequencing. PIPE_PERF_EN adds counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             mem_indirect,
    input  logic             dmem_resp,
    input  logic             load_use,
    input  logic             branch_taken,
    output logic             imem_read,
    output logic             dmem_en,
    output logic             ind_phase,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_clear,
    output logic             id_ex_clear,
    output logic             ex_mem_clear,
    output logic             mem_wb_clear,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    ind_phase_t ind_q, ind_d;
    logic       imem_done_q, imem_done_d;
    logic       dmem_done_q, dmem_done_d;
    logic       imem_ok, dmem_final, dmem_ok, advance;

    assign imem_ok    = imem_resp | imem_done_q;
    assign dmem_final = dmem_resp & (~mem_indirect | (ind_q == PH_SECOND));
    assign dmem_ok    = ~dmem_req | dmem_final | dmem_done_q;
    assign advance    = imem_ok & dmem_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ind_q       <= PH_FIRST;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            ind_q       <= ind_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    always_comb begin
        ind_d        = ind_q;
        imem_done_d  = imem_done_q;
        dmem_done_d  = dmem_done_q;
        imem_read    = 1'b0;
        dmem_en      = 1'b0;
        ind_phase    = 1'b0;
        pc_load      = 1'b0;
        if_id_load   = 1'b0;
        id_ex_load   = 1'b0;
        ex_mem_load  = 1'b0;
        mem_wb_load  = 1'b0;
        if_id_clear  = 1'b0;
        id_ex_clear  = 1'b0;
        ex_mem_clear = 1'b0;
        mem_wb_clear = 1'b0;
        if (reset) begin
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            ex_mem_clear = 1'b1;
            mem_wb_clear = 1'b1;
        end else begin
            imem_read = ~imem_done_q;
            dmem_en   = dmem_req & ~dmem_done_q;
            ind_phase = (ind_q == PH_SECOND);
            if (!advance) begin
                // Frozen: latch whichever responses arrived so they are not re-requested.
                imem_done_d = imem_done_q | imem_resp;
                dmem_done_d = dmem_done_q | dmem_final;
                if (dmem_resp && mem_indirect && ind_q == PH_FIRST)
                    ind_d = PH_SECOND;
            end else begin
                ind_d       = PH_FIRST;
                imem_done_d = 1'b0;
                dmem_done_d = 1'b0;
                if (branch_taken) begin
                    {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b11111;
                    {if_id_clear, id_ex_clear, ex_mem_clear} = 3'b111;
                end else if (load_use) begin
                    // Hold PC and IF/ID, bubble into ID/EX.
                    {id_ex_load, ex_mem_load, mem_wb_load} = 3'b111;
                    id_ex_clear = 1'b1;
                end else begin
                    {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b11111;
                end
            end
        end
    end

`ifdef PIPE_PERF_EN
    logic stall_inc, flush_inc;
    assign stall_inc = ~advance | (load_use & ~branch_taken);
    assign flush_inc = advance & branch_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_inc), .count(stall_count)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(flush_inc), .count(flush_count)
    );
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a
// transaction-level model (fetch seen, data responses counted per instruction).
module tb_pipe_ctrl;

    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    logic imem_resp, dmem_req, mem_indirect, dmem_resp, load_use, branch_taken;
    logic imem_read, dmem_en, ind_phase;
    logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
    logic [CW-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    // model state: fetch word received, data responses received for the MEM instruction
    bit m_fetched;
    int m_ndr;
    int m_stall, m_flush;
    bit m_adv;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .imem_resp(imem_resp), .dmem_req(dmem_req), .mem_indirect(mem_indirect),
        .dmem_resp(dmem_resp), .load_use(load_use), .branch_taken(branch_taken),
        .imem_read(imem_read), .dmem_en(dmem_en), .ind_phase(ind_phase),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear),
        .ex_mem_clear(ex_mem_clear), .mem_wb_clear(mem_wb_clear),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ctl_vec();
        return {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear};
    endfunction

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef PIPE_PERF_EN
        return (v > 32'hFFFF) ? 32'hFFFF : v;
`else
        return (v == v) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_fetched = 0;
        m_ndr     = 0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ctl"}, {23'd0, ctl_vec()}, 32'h00F);
        chk({tag, ".str"}, {29'd0, imem_read, dmem_en, ind_phase}, 32'd0);
        chk({tag, ".stc"}, {16'd0, stall_count}, 32'd0);
        chk({tag, ".flc"}, {16'd0, flush_count}, 32'd0);
    endtask

    // Called just after a negedge: drive inputs, check, then advance the model
    // to the state it will hold after the coming posedge.
    task automatic step(input string tag, input logic ir, dr, mi, drs, lu, bt);
        int need;
        bit dok, adv;
        logic [8:0] ctl;
        imem_resp = ir; dmem_req = dr; mem_indirect = mi;
        dmem_resp = drs; load_use = lu; branch_taken = bt;
        #1;
        need = mi ? 2 : 1;
        dok  = !dr || (m_ndr >= need) || (drs && (m_ndr + 1 >= need));
        adv  = (m_fetched || ir) && dok;
        if (!adv)    ctl = 9'b00000_0000;
        else if (bt) ctl = 9'b11111_1110;
        else if (lu) ctl = 9'b00111_0100;
        else         ctl = 9'b11111_0000;
        chk({tag, ".ctl"}, {23'd0, ctl_vec()}, {23'd0, ctl});
        chk({tag, ".imrd"}, {31'd0, imem_read}, {31'd0, !m_fetched});
        chk({tag, ".den"}, {31'd0, dmem_en}, {31'd0, dr && (m_ndr < need)});
        chk({tag, ".ind"}, {31'd0, ind_phase}, {31'd0, mi && (m_ndr >= 1)});
        chk({tag, ".stc"}, {16'd0, stall_count}, cnt_exp(m_stall));
        chk({tag, ".flc"}, {16'd0, flush_count}, cnt_exp(m_flush));
        if (!adv || (lu && !bt)) m_stall++;
        if (adv && bt) m_flush++;
        if (adv) begin
            m_fetched = 0;
            m_ndr     = 0;
        end else begin
            if (ir) m_fetched = 1;
            if (dr && drs && m_ndr < need) m_ndr++;
        end
        m_adv = adv;
    endtask

    initial begin
        bit dr, mi;
        int guard;
        reset = 1'b1;
        {imem_resp, dmem_req, mem_indirect, dmem_resp, load_use, branch_taken} = '0;
        model_reset();
        #1 chk_reset("rst0");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // idle pipeline, fetch always ready
        for (int i = 0; i < 4; i++) step("idle", 1, 0, 0, 0, 0, 0);

        // slow data memory: fetch on cycle 1, data on cycle 3
        @(negedge clk) step("slow1", 1, 1, 0, 0, 0, 0);
        @(negedge clk) step("slow2", 0, 1, 0, 0, 0, 0);
        @(negedge clk) step("slow3", 0, 1, 0, 1, 0, 0);
        chk("slow.adv", {31'd0, m_adv}, 32'd1);

        // LDI: responses on cycles 2 and 4
        @(negedge clk) step("ldi1", 1, 1, 1, 0, 0, 0);
        @(negedge clk) step("ldi2", 0, 1, 1, 1, 0, 0);
        @(negedge clk) step("ldi3", 0, 1, 1, 0, 0, 0);
        @(negedge clk) step("ldi4", 0, 1, 1, 1, 0, 0);
        chk("ldi.adv", {31'd0, m_adv}, 32'd1);

        // load-use, then branch together with load-use, then branch during stall
        @(negedge clk) step("lu", 1, 0, 0, 0, 1, 0);
        @(negedge clk) step("brlu", 1, 0, 0, 0, 1, 1);
        @(negedge clk) step("brst1", 0, 1, 0, 0, 0, 1);
        @(negedge clk) step("brst2", 1, 1, 0, 1, 0, 1);

        // reset while in the second LDI phase
        @(negedge clk) step("rldi1", 1, 1, 1, 1, 0, 0);
        chk("rldi.ph", {31'd0, ind_phase}, 32'd0);
        @(negedge clk) begin
            imem_resp = 1'b0; dmem_resp = 1'b0;
            #2 chk("rldi.ph2", {31'd0, ind_phase}, 32'd1);
            reset = 1'b1;
            #1 chk_reset("rldi");
            chk("rldi.den", {31'd0, dmem_en}, 32'd0);
        end
        model_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) step("rldi2", 1, 1, 1, 1, 0, 0);
        chk("rldi2.adv", {31'd0, m_adv}, 32'd0);
        @(negedge clk) step("rldi3", 0, 1, 1, 1, 0, 0);
        chk("rldi3.adv", {31'd0, m_adv}, 32'd1);

        // random traffic: memory-op attributes held until the instruction leaves MEM
        dr = 0; mi = 0; guard = 0;
        for (int i = 0; i < 400; i++) begin
            bit ir, drs, lu, bt;
            @(negedge clk);
            ir  = ($urandom_range(0, 2) != 0);
            drs = dr && (m_ndr < (mi ? 2 : 1)) && ($urandom_range(0, 2) == 0);
            lu  = ($urandom_range(0, 3) == 0);
            bt  = ($urandom_range(0, 4) == 0);
            step("rnd", ir, dr, mi, drs, lu, bt);
            guard = m_adv ? 0 : guard + 1;
            if (guard > 200) begin
                chk("rnd.stuck", 32'd1, {31'd0, m_adv});
                break;
            end
            if (m_adv) begin
                dr = $urandom_range(0, 1);
                mi = dr && ($urandom_range(0, 1) == 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
